yutorina_bus_arbiter: RTL and testbench

- Round-robin arbiter and request multiplexer for the shared external memory bus.
- Up to four bus masters connect through their bus interface request/grant pins: instruction fetch, the memory stage, a DMA engine, and a debug port.
- Grants ownership, holds it while the owner keeps requesting, and steers the owner's access signals onto the single slave-side bus.
- Sits between the CPU pipeline bus interfaces and the bus slaves/decoder.

---
 rtl/yutorina_bus_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_yutorina_bus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/yutorina_bus_arbiter.sv
// ---------------------------------------------------------------------------
// yutorina_bus_arbiter
//   Round-robin arbiter and request multiplexer for the shared external
//   memory bus. Four masters (instruction fetch, memory stage, DMA, debug)
//   request with active-low m_req_. The arbiter grants one owner, holds the
//   grant while the owner keeps requesting, and steers the owner's access
//   signals onto the single slave-side bus.
//
//   Optional feature macro: YUTORINA_BUS_WDT_EN
//     Defined   : a bus watchdog revokes the grant when the owner's access
//                 waits WDT_CYCLES cycles for s_rdy_, and pulses wdt_err_.
//     Undefined : no watchdog; wdt_err_ is tied inactive.
// ---------------------------------------------------------------------------
module yutorina_bus_arbiter #(
   parameter int MASTERS    = 4,   // fixed at 4 (2-bit owner id)
   parameter int WDT_CYCLES = 16   // watchdog limit, used only with the watchdog
) (
   input  logic                    clk,
   input  logic                    rst,        // asynchronous, active-low
   input  logic [MASTERS-1:0]      m_req_,
   output logic [MASTERS-1:0]      m_grnt_,
   input  logic [MASTERS-1:0]      m_as_,
   input  logic [MASTERS-1:0]      m_rw,
   input  logic [MASTERS*30-1:0]   m_addr,
   input  logic [MASTERS*32-1:0]   m_w_data,
   output logic                    s_as_,
   output logic                    s_rw,
   output logic [29:0]             s_addr,
   output logic [31:0]             s_w_data,
   input  logic                    s_rdy_,
   output logic [1:0]              owner,
   output logic                    busy,
   output logic                    wdt_err_
);

   // Bus signalling levels used across the CPU bus fabric.
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;
   localparam logic READ     = 1'b1;

   localparam int  AW = 30;
   localparam int  DW = 32;

   localparam logic [3:0] GRNT_NONE = 4'b1111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // Registered arbiter state
   // -------------------------------------------------------------------------
   state_t        state_q;
   logic [3:0]    grnt_q;      // active-low grant vector
   logic [1:0]    owner_q;     // current (or most recently revoked) owner
   logic [1:0]    last_q;      // round-robin pointer: last granted master

   // Combinational arbitration results
   logic [3:0]    req_act;     // active-high request vector
   logic [3:0]    owner_mask;  // one-hot of the current owner
   logic          owner_req;   // owner still requesting
   logic          idle_found;
   logic [1:0]    idle_idx;
   logic          ho_found;
   logic [1:0]    ho_idx;
   logic          wdt_expire;  // watchdog fires on this edge

   // -------------------------------------------------------------------------
   // Round-robin pick: scan (last+1), (last+2), (last+3), last (mod 4) and
   // return {found, index} of the first active requester.
   // -------------------------------------------------------------------------
   function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] last);
      logic       found;
      logic [1:0] idx;
      logic [1:0] cand;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   // Active-low one-hot grant vector for a given master index.
   function automatic logic [3:0] grant_of(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // Request decoding and both arbitration scans (from IDLE and at handoff).
   always_comb begin
      req_act    = ~m_req_;
      owner_mask = 4'b0001 << owner_q;
      owner_req  = req_act[owner_q];
      {idle_found, idle_idx} = rr_pick(req_act, last_q);
      // At handoff the releasing owner is excluded and scanned from itself,
      // so it can never win twice in a row over another requester.
      {ho_found, ho_idx}     = rr_pick(req_act & ~owner_mask, owner_q);
   end

`ifdef YUTORINA_BUS_WDT_EN
   // -------------------------------------------------------------------------
   // Bus watchdog
   // -------------------------------------------------------------------------
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] wdt_q;
   logic [WDT_W-1:0] wdt_d;
   logic             wdt_err_q;
   logic             wdt_stall;  // owner strobing while slave is not ready

   // Count stalled cycles of the holding owner; clear on ready, handoff, idle.
   always_comb begin
      wdt_stall  = (state_q == ST_OWNED) && owner_req &&
                   (m_as_[owner_q] == ENABLE_) && (s_rdy_ == DISABLE_);
      wdt_expire = wdt_stall && (wdt_q == WDT_W'(WDT_CYCLES - 1));
      wdt_d      = '0;
      if ((state_q == ST_OWNED) && owner_req && (s_rdy_ == DISABLE_)) begin
         if (wdt_expire)
            wdt_d = '0;
         else if (wdt_stall)
            wdt_d = wdt_q + 1'b1;
         else
            wdt_d = wdt_q;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wdt_q <= '0;
      else
         wdt_q <= wdt_d;
   end

   assign wdt_err_ = wdt_err_q;
`else
   logic unused_wdt_s_rdy;
   localparam int unused_wdt_cycles = WDT_CYCLES;

   always_comb wdt_expire = 1'b0;

   assign unused_wdt_s_rdy = s_rdy_;
   assign wdt_err_         = DISABLE_;
`endif

   // -------------------------------------------------------------------------
   // Arbiter FSM: grant from IDLE, hold while owner requests, hand off with
   // zero dead cycles, or release to IDLE. Outputs are the registers.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         grnt_q    <= GRNT_NONE;
         owner_q   <= 2'd0;
         last_q    <= 2'd3;
`ifdef YUTORINA_BUS_WDT_EN
         wdt_err_q <= DISABLE_;
`endif
      end else begin
`ifdef YUTORINA_BUS_WDT_EN
         wdt_err_q <= DISABLE_;
`endif
         case (state_q)
            ST_IDLE: begin
               if (idle_found) begin
                  grnt_q  <= grant_of(idle_idx);
                  owner_q <= idle_idx;
                  last_q  <= idle_idx;
                  state_q <= ST_OWNED;
               end
            end
            ST_OWNED: begin
               if (owner_req) begin
                  if (wdt_expire) begin
                     // Revoke the hung owner; owner_q keeps naming the
                     // offender and last_q = offender puts it last in line.
                     grnt_q    <= GRNT_NONE;
                     state_q   <= ST_IDLE;
`ifdef YUTORINA_BUS_WDT_EN
                     wdt_err_q <= ENABLE_;
`endif
                  end
               end else if (ho_found) begin
                  grnt_q  <= grant_of(ho_idx);
                  owner_q <= ho_idx;
                  last_q  <= ho_idx;
               end else begin
                  grnt_q  <= GRNT_NONE;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               grnt_q  <= GRNT_NONE;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_grnt_ = grnt_q;
   assign owner   = owner_q;
   assign busy    = ~&grnt_q;

   // Slave-side mux: owner's access when busy, idle bus values otherwise.
   always_comb begin
      s_as_    = DISABLE_;
      s_rw     = READ;
      s_addr   = '0;
      s_w_data = '0;
      if (busy) begin
         for (int k = 0; k < MASTERS; k++) begin
            if (owner_q == 2'(k)) begin
               s_as_    = m_as_[k];
               s_rw     = m_rw[k];
               s_addr   = m_addr[AW*k +: AW];
               s_w_data = m_w_data[DW*k +: DW];
            end
         end
      end
   end

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_yutorina_bus_arbiter
//   Directed self-checking bench for the round-robin bus arbiter.
//   Watchdog scenario is selected with YUTORINA_BUS_WDT_EN.
// ---------------------------------------------------------------------------
module tb_yutorina_bus_arbiter;

   logic          clk;
   logic          rst;
   logic [3:0]    m_req_;
   logic [3:0]    m_grnt_;
   logic [3:0]    m_as_;
   logic [3:0]    m_rw;
   logic [119:0]  m_addr;
   logic [127:0]  m_w_data;
   logic          s_as_;
   logic          s_rw;
   logic [29:0]   s_addr;
   logic [31:0]   s_w_data;
   logic          s_rdy_;
   logic [1:0]    owner;
   logic          busy;
   logic          wdt_err_;

   int checks = 0;
   int errors = 0;

   yutorina_bus_arbiter #(.MASTERS(4), .WDT_CYCLES(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .m_req_   (m_req_),
      .m_grnt_  (m_grnt_),
      .m_as_    (m_as_),
      .m_rw     (m_rw),
      .m_addr   (m_addr),
      .m_w_data (m_w_data),
      .s_as_    (s_as_),
      .s_rw     (s_rw),
      .s_addr   (s_addr),
      .s_w_data (s_w_data),
      .s_rdy_   (s_rdy_),
      .owner    (owner),
      .busy     (busy),
      .wdt_err_ (wdt_err_)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst    = 1'b0;
      m_req_ = 4'b1111;
      m_as_  = 4'b0000;
      m_rw   = 4'b0101;
      s_rdy_ = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_addr[30*i +: 30]   = 30'h100 + 30'(i);
         m_w_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
      end
      tick();
      tick();
      checks++; if (m_grnt_ !== 4'b1111) begin errors++; $display("FAIL reset_grnt got %b exp %b", m_grnt_, 4'b1111); end
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (wdt_err_ !== 1'b1) begin errors++; $display("FAIL reset_wdt_err got %b exp 1", wdt_err_); end
      checks++; if (s_as_ !== 1'b1 || s_addr !== 30'd0) begin errors++; $display("FAIL reset_slave got as=%b addr=%h exp as=1 addr=0", s_as_, s_addr); end
      rst = 1'b1;
      tick();
      checks++; if (m_grnt_ !== 4'b1111) begin errors++; $display("FAIL reset_idle_grnt got %b exp 1111", m_grnt_); end
   endtask

   task automatic test_first_grant();
      m_req_ = 4'b1110;
      #1;
      checks++; if (m_grnt_ !== 4'b1111) begin errors++; $display("FAIL grant_latency got %b exp 1111", m_grnt_); end
      tick();
      checks++; if (m_grnt_ !== 4'b1110) begin errors++; $display("FAIL grant0_grnt got %b exp 1110", m_grnt_); end
      checks++; if (owner !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL grant0_owner got owner=%0d busy=%b exp owner=0 busy=1", owner, busy); end
      checks++; if (s_addr !== 30'h100 || s_w_data !== 32'hA000_0000) begin errors++; $display("FAIL grant0_mux got addr=%h data=%h exp 100/a0000000", s_addr, s_w_data); end
      checks++; if (s_as_ !== 1'b0 || s_rw !== 1'b1) begin errors++; $display("FAIL grant0_ctl got as=%b rw=%b exp as=0 rw=1", s_as_, s_rw); end
   endtask

   task automatic test_no_preempt();
      m_req_ = 4'b1010;
      tick();
      tick();
      checks++; if (m_grnt_ !== 4'b1110 || owner !== 2'd0) begin errors++; $display("FAIL no_preempt got %b owner=%0d exp 1110 owner=0", m_grnt_, owner); end
      m_req_ = 4'b1011;
      tick();
      checks++; if (m_grnt_ !== 4'b1011 || owner !== 2'd2) begin errors++; $display("FAIL handoff_2 got %b owner=%0d exp 1011 owner=2", m_grnt_, owner); end
      checks++; if (s_addr !== 30'h102 || s_rw !== 1'b1) begin errors++; $display("FAIL handoff_2_mux got addr=%h rw=%b exp 102 rw=1", s_addr, s_rw); end
      m_req_ = 4'b1111;
      tick();
      checks++; if (m_grnt_ !== 4'b1111 || busy !== 1'b0) begin errors++; $display("FAIL release_2 got %b busy=%b exp 1111 busy=0", m_grnt_, busy); end
   endtask

   task automatic test_round_robin();
      logic [1:0] e;
      logic [3:0] exp_g;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      m_req_ = 4'b0000;
      tick();
      for (int n = 0; n < 5; n++) begin
         e     = 2'(n % 4);
         exp_g = ~(4'b0001 << e);
         checks++; if (m_grnt_ !== exp_g || owner !== e) begin errors++; $display("FAIL rr_grant%0d got %b owner=%0d exp %b owner=%0d", n, m_grnt_, owner, exp_g, e); end
         checks++; if (s_addr !== 30'h100 + 30'(e)) begin errors++; $display("FAIL rr_mux%0d got %h exp %h", n, s_addr, 30'h100 + 30'(e)); end
         tick();
         tick();
         checks++; if (m_grnt_ !== exp_g) begin errors++; $display("FAIL rr_hold%0d got %b exp %b", n, m_grnt_, exp_g); end
         if (n == 4) m_req_ = 4'b1111;
         else        m_req_[e] = 1'b1;
         tick();
         m_req_[e] = (n == 4) ? 1'b1 : 1'b0;
      end
      checks++; if (m_grnt_ !== 4'b1111 || busy !== 1'b0) begin errors++; $display("FAIL rr_end got %b busy=%b exp 1111 busy=0", m_grnt_, busy); end
   endtask

   task automatic test_release_regrant();
      m_req_ = 4'b1101;
      tick();
      checks++; if (m_grnt_ !== 4'b1101 || owner !== 2'd1) begin errors++; $display("FAIL own1 got %b owner=%0d exp 1101 owner=1", m_grnt_, owner); end
      checks++; if (s_rw !== 1'b0 || s_w_data !== 32'hA000_0001) begin errors++; $display("FAIL own1_mux got rw=%b data=%h exp rw=0 a0000001", s_rw, s_w_data); end
      m_req_ = 4'b1111;
      tick();
      checks++; if (m_grnt_ !== 4'b1111 || busy !== 1'b0) begin errors++; $display("FAIL rel1 got %b busy=%b exp 1111 busy=0", m_grnt_, busy); end
      checks++; if (s_as_ !== 1'b1 || s_addr !== 30'd0 || s_w_data !== 32'd0 || s_rw !== 1'b1) begin errors++; $display("FAIL rel1_idle_bus got as=%b addr=%h data=%h rw=%b exp 1/0/0/1", s_as_, s_addr, s_w_data, s_rw); end
      m_req_ = 4'b1101;
      tick();
      checks++; if (m_grnt_ !== 4'b1101 || owner !== 2'd1) begin errors++; $display("FAIL regrant1 got %b owner=%0d exp 1101 owner=1", m_grnt_, owner); end
   endtask

   task automatic test_async_reset();
      m_req_ = 4'b0111;
      tick();
      checks++; if (m_grnt_ !== 4'b0111 || owner !== 2'd3) begin errors++; $display("FAIL handoff_3 got %b owner=%0d exp 0111 owner=3", m_grnt_, owner); end
      checks++; if (s_as_ !== 1'b0 || s_addr !== 30'h103) begin errors++; $display("FAIL handoff_3_mux got as=%b addr=%h exp 0/103", s_as_, s_addr); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (m_grnt_ !== 4'b1111 || busy !== 1'b0) begin errors++; $display("FAIL async_rst_grnt got %b busy=%b exp 1111 busy=0", m_grnt_, busy); end
      checks++; if (s_as_ !== 1'b1 || s_addr !== 30'd0 || owner !== 2'd0) begin errors++; $display("FAIL async_rst_bus got as=%b addr=%h owner=%0d exp 1/0/0", s_as_, s_addr, owner); end
      rst    = 1'b1;
      m_req_ = 4'b1111;
      tick();
   endtask

   task automatic test_watchdog();
      m_req_ = 4'b1011;
      m_as_  = 4'b1011;
      s_rdy_ = 1'b1;
      tick();
      checks++; if (m_grnt_ !== 4'b1011 || owner !== 2'd2) begin errors++; $display("FAIL wdt_own2 got %b owner=%0d exp 1011 owner=2", m_grnt_, owner); end
      m_req_ = 4'b0011;
`ifdef YUTORINA_BUS_WDT_EN
      for (int i = 1; i < 16; i++) begin
         tick();
         checks++; if (m_grnt_ !== 4'b1011 || wdt_err_ !== 1'b1) begin errors++; $display("FAIL wdt_hold%0d got %b err=%b exp 1011 err=1", i, m_grnt_, wdt_err_); end
      end
      tick();
      checks++; if (m_grnt_ !== 4'b1111 || wdt_err_ !== 1'b0 || owner !== 2'd2) begin errors++; $display("FAIL wdt_revoke got %b err=%b owner=%0d exp 1111 err=0 owner=2", m_grnt_, wdt_err_, owner); end
      tick();
      checks++; if (wdt_err_ !== 1'b1) begin errors++; $display("FAIL wdt_pulse_width got err=%b exp 1", wdt_err_); end
      checks++; if (m_grnt_ !== 4'b0111 || owner !== 2'd3) begin errors++; $display("FAIL wdt_next3 got %b owner=%0d exp 0111 owner=3", m_grnt_, owner); end
`else
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++; if (m_grnt_ !== 4'b1011 || wdt_err_ !== 1'b1) begin errors++; $display("FAIL hung_hold%0d got %b err=%b exp 1011 err=1", i, m_grnt_, wdt_err_); end
      end
`endif
      m_req_ = 4'b1111;
      m_as_  = 4'b0000;
      s_rdy_ = 1'b0;
      tick();
      tick();
      checks++; if (m_grnt_ !== 4'b1111 || busy !== 1'b0) begin errors++; $display("FAIL wdt_end got %b busy=%b exp 1111 busy=0", m_grnt_, busy); end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_no_preempt();
      test_round_robin();
      test_release_regrant();
      test_async_reset();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
